// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared types and constants for the VRAM write arbiter
// (and the read-side arbiter that reuses rr_picker).
package vram_arb_pkg;

   localparam int DEF_ADDR_WIDTH = 24;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_STRB_WIDTH = DEF_DATA_WIDTH / 8;

   // Longest run of consecutive locked accepts before the pointer is forced on.
   localparam int LOCK_MAX = 16;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic [DEF_ADDR_WIDTH-1:0] addr;
      logic [DEF_DATA_WIDTH-1:0] data;
      logic [DEF_STRB_WIDTH-1:0] strb;
   } vram_wr_t;

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin winner search.
// The first set bit of req at or above ptr (wrapping modulo NUM_REQ) wins.
module rr_picker #(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [ID_WIDTH-1:0] ptr,
   output logic [NUM_REQ-1:0]  grant,
   output logic [ID_WIDTH-1:0] idx,
   output logic                any
);

   // Scan from the farthest offset back towards ptr so the nearest requester is written last.
   always_comb begin
      logic [ID_WIDTH-1:0] j;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
         if (req[j]) begin
            any = 1'b1;
            idx = j;
         end
      end
      if (any) grant[idx] = 1'b1;
   end

endmodule

// File: rtl/vram_wr_arbiter.sv
// vram_wr_arbiter: round-robin sharing of the single VRAM write port with one
// registered output slot; mem_ready retires the slot and may refill it the same cycle.
// Optional macro VRAM_WR_ARBITER_LOCK_EN adds req_lock: a locked winner keeps top
// priority for up to LOCK_MAX consecutive accepts.
module vram_wr_arbiter
   import vram_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ*STRB_WIDTH-1:0] req_strb,
`ifdef VRAM_WR_ARBITER_LOCK_EN
   input  logic [NUM_REQ-1:0]            req_lock,
`endif
   output logic [ADDR_WIDTH-1:0]         waddr,
   output logic [DATA_WIDTH-1:0]         wdata,
   output logic [STRB_WIDTH-1:0]         wstrb,
   output logic                          wen,
   input  logic                          mem_ready,
   output logic [ID_WIDTH-1:0]           grant_id,
   output logic                          busy
);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
      logic [STRB_WIDTH-1:0] strb;
   } slot_t;

   logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_a;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_a;
   logic [NUM_REQ-1:0][STRB_WIDTH-1:0] strb_a;

   arb_state_t          state;
   slot_t               slot;
   slot_t               pick_wr;
   logic [ID_WIDTH-1:0] ptr;
   logic [ID_WIDTH-1:0] pick_idx;
   logic [ID_WIDTH-1:0] ptr_inc;
   logic [ID_WIDTH-1:0] next_ptr;
   logic [NUM_REQ-1:0]  pick_grant;
   logic                pick_any;
   logic                can_accept;
   logic                accept;

   assign addr_a = req_addr;
   assign data_a = req_data;
   assign strb_a = req_strb;

   rr_picker #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_pick (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // The slot can take a new write if it is empty or is being drained this cycle.
   assign can_accept = (state == EMPTY) || mem_ready;
   assign accept     = pick_any && can_accept && !rst;
   assign req_ready  = accept ? pick_grant : '0;
   assign pick_wr    = {addr_a[pick_idx], data_a[pick_idx], strb_a[pick_idx]};
   assign ptr_inc    = (pick_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

`ifdef VRAM_WR_ARBITER_LOCK_EN
   logic [3:0] lock_cnt;
   logic       lock_hold;

   // A locked winner keeps the pointer unless this accept completes a full run.
   assign lock_hold = req_lock[pick_idx] && (lock_cnt != 4'(LOCK_MAX - 1));
   assign next_ptr  = lock_hold ? pick_idx : ptr_inc;

   // Run length of consecutive locked accepts; any unlocked or run-ending accept clears it.
   always_ff @(posedge clk) begin
      if (rst)         lock_cnt <= '0;
      else if (accept) lock_cnt <= lock_hold ? lock_cnt + 4'd1 : 4'd0;
   end
`else
   assign next_ptr = ptr_inc;
`endif

   // Slot FSM: load on accept, clear on retire; the port is driven straight from these flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= EMPTY;
         slot     <= '0;
         grant_id <= '0;
         ptr      <= '0;
      end else if (accept) begin
         state    <= FULL;
         slot     <= pick_wr;
         grant_id <= pick_idx;
         ptr      <= next_ptr;
      end else if (state == FULL && mem_ready) begin
         state    <= EMPTY;
         slot     <= '0;
      end
   end

   assign wen   = (state == FULL);
   assign waddr = slot.addr;
   assign wdata = slot.data;
   assign wstrb = slot.strb;
   assign busy  = wen || (|req_valid);

endmodule

// File: tb/tb_vram_wr_arbiter.sv
// tb_vram_wr_arbiter: directed vector table, lock-run sequence (when the lock
// build is selected) and a randomized run checked against a transaction-level model.
module tb_vram_wr_arbiter;
   import vram_arb_pkg::*;

   localparam int N  = 4;
   localparam int AW = DEF_ADDR_WIDTH;
   localparam int DW = DEF_DATA_WIDTH;
   localparam int SW = DW / 8;
   localparam int IW = 2;

   logic                 clk       = 1'b0;
   logic                 rst       = 1'b1;
   logic                 mem_ready = 1'b0;
   logic [N-1:0]         req_valid = '0;
   logic [N-1:0]         req_ready;
   logic [N-1:0][AW-1:0] ra = '0;
   logic [N-1:0][DW-1:0] rd = '0;
   logic [N-1:0][SW-1:0] rs = '0;
   logic [AW-1:0]        waddr;
   logic [DW-1:0]        wdata;
   logic [SW-1:0]        wstrb;
   logic                 wen;
   logic [IW-1:0]        grant_id;
   logic                 busy;
`ifdef VRAM_WR_ARBITER_LOCK_EN
   logic [N-1:0]         req_lock = '0;
`endif

   vram_wr_arbiter #(.NUM_REQ(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (ra),
      .req_data  (rd),
      .req_strb  (rs),
`ifdef VRAM_WR_ARBITER_LOCK_EN
      .req_lock  (req_lock),
`endif
      .waddr     (waddr),
      .wdata     (wdata),
      .wstrb     (wstrb),
      .wen       (wen),
      .mem_ready (mem_ready),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: one pending write, a priority pointer and the grant owner.
   logic     m_full = 1'b0;
   vram_wr_t m_wr   = '0;
   int       m_gid  = 0;
   int       m_ptr  = 0;
   int       m_run  = 0;
   int       obs_wait [N];

   logic [N-1:0] m_acc;
   logic [N-1:0] pre_ready, exp_ready, pre_valid;
   logic         pre_busy, exp_busy;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int winner(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++)
         if (v[IW'((p + k) % N)]) return (p + k) % N;
      return -1;
   endfunction

   function automatic logic [N-1:0] model_ready();
      int w;
      w = winner(req_valid, m_ptr);
      if (rst || w < 0 || (m_full && !mem_ready)) return '0;
      return N'(1) << w;
   endfunction

   task automatic model_edge();
      int w;
      m_acc = '0;
      if (rst) begin
         m_full = 1'b0; m_wr = '0; m_gid = 0; m_ptr = 0; m_run = 0;
         return;
      end
      w = winner(req_valid, m_ptr);
      if (w >= 0 && (!m_full || mem_ready)) begin
         m_acc  = N'(1) << w;
         m_full = 1'b1;
         m_wr   = {ra[IW'(w)], rd[IW'(w)], rs[IW'(w)]};
         m_gid  = w;
`ifdef VRAM_WR_ARBITER_LOCK_EN
         if (req_lock[IW'(w)] && m_run < LOCK_MAX - 1) begin
            m_run++;
            m_ptr = w;
         end else begin
            m_run = 0;
            m_ptr = (w + 1) % N;
         end
`else
         m_ptr = (w + 1) % N;
`endif
      end else if (m_full && mem_ready) begin
         m_full = 1'b0;
         m_wr   = '0;
      end
   endtask

   // One clock: sample combinational outputs before the edge, advance model, settle after.
   task automatic step();
      #2;
      pre_ready = req_ready;
      pre_busy  = busy;
      pre_valid = req_valid;
      exp_ready = model_ready();
      exp_busy  = m_full || (|req_valid);
      @(posedge clk);
      model_edge();
      // How many other accepts each waiting requester has seen, from the DUT's own grants.
      for (int i = 0; i < N; i++) begin
         if (rst || !pre_valid[i] || pre_ready[i]) obs_wait[i] = 0;
         else if (|pre_ready)                      obs_wait[i]++;
      end
      #1;
   endtask

   typedef struct {
      logic          r;
      logic [N-1:0]  v;
      logic          mr;
      logic [N-1:0]  ready;
      logic          wen;
      logic [AW-1:0] waddr;
      logic [IW-1:0] gid;
   } vec_t;

   vec_t tbl [25];

   localparam logic [AW-1:0] A0 = 24'h000010, A1 = 24'h000020, A2 = 24'h000100, A3 = 24'h000040;
   logic [DW-1:0] td [N];
   logic [SW-1:0] ts [N];

   initial begin
      int mx;
      for (int i = 0; i < N; i++) obs_wait[i] = 0;
      td[0] = 32'h11111111; td[1] = 32'h22222222; td[2] = 32'hDEADBEEF; td[3] = 32'h44444444;
      ts[0] = 4'hF; ts[1] = 4'h3; ts[2] = 4'hF; ts[3] = 4'h0;
      ra[0] = A0; ra[1] = A1; ra[2] = A2; ra[3] = A3;
      for (int i = 0; i < N; i++) begin rd[i] = td[i]; rs[i] = ts[i]; end

      //            rst   valid  mrdy  ready  wen   waddr  gid
      tbl[0]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 24'h0, 2'd0};
      tbl[1]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 24'h0, 2'd0};
      tbl[2]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 24'h0, 2'd0};
      tbl[3]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, A0,    2'd0};
      tbl[4]  = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, A1,    2'd1};
      tbl[5]  = '{1'b0, 4'hF, 1'b1, 4'h4, 1'b1, A2,    2'd2};
      tbl[6]  = '{1'b0, 4'hF, 1'b1, 4'h8, 1'b1, A3,    2'd3};
      tbl[7]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, A0,    2'd0};
      tbl[8]  = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, A1,    2'd1};
      for (int r = 9; r <= 13; r++)
         tbl[r] = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, A1, 2'd1};
      tbl[14] = '{1'b0, 4'hF, 1'b1, 4'h4, 1'b1, A2,    2'd2};
      tbl[15] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 24'h0, 2'd2};
      tbl[16] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 24'h0, 2'd2};
      tbl[17] = '{1'b0, 4'h4, 1'b1, 4'h4, 1'b1, A2,    2'd2};
      tbl[18] = '{1'b0, 4'h4, 1'b1, 4'h4, 1'b1, A2,    2'd2};
      tbl[19] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, A2,    2'd2};
      tbl[20] = '{1'b0, 4'h9, 1'b0, 4'h0, 1'b1, A2,    2'd2};
      tbl[21] = '{1'b1, 4'h9, 1'b0, 4'h0, 1'b0, 24'h0, 2'd0};
      tbl[22] = '{1'b0, 4'hA, 1'b0, 4'h2, 1'b1, A1,    2'd1};
      tbl[23] = '{1'b0, 4'h8, 1'b1, 4'h8, 1'b1, A3,    2'd3};
      tbl[24] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 24'h0, 2'd3};

      for (int r = 0; r < 25; r++) begin
         rst = tbl[r].r; req_valid = tbl[r].v; mem_ready = tbl[r].mr;
         step();
         chk($sformatf("vec%0d_ready", r), 64'(pre_ready), 64'(tbl[r].ready));
         if (r > 0)
            chk($sformatf("vec%0d_busy", r), 64'(pre_busy), 64'(tbl[r-1].wen || (|tbl[r].v)));
         chk($sformatf("vec%0d_wen", r),   64'(wen),      64'(tbl[r].wen));
         chk($sformatf("vec%0d_waddr", r), 64'(waddr),    64'(tbl[r].waddr));
         chk($sformatf("vec%0d_wdata", r), 64'(wdata),    tbl[r].wen ? 64'(td[tbl[r].gid]) : 64'd0);
         chk($sformatf("vec%0d_wstrb", r), 64'(wstrb),    tbl[r].wen ? 64'(ts[tbl[r].gid]) : 64'd0);
         chk($sformatf("vec%0d_gid", r),   64'(grant_id), 64'(tbl[r].gid));
      end

`ifdef VRAM_WR_ARBITER_LOCK_EN
      // Locked requester 0 holds priority for exactly LOCK_MAX accepts, then 3 gets in.
      rst = 1'b1; req_valid = '0; req_lock = '0; mem_ready = 1'b1;
      step();
      rst = 1'b0; req_valid = 4'b1001; req_lock = 4'b0001;
      for (int k = 0; k <= LOCK_MAX; k++) begin
         step();
         chk($sformatf("lock%0d_gid", k), 64'(grant_id), (k < LOCK_MAX) ? 64'd0 : 64'd3);
         chk($sformatf("lock%0d_wen", k), 64'(wen), 64'd1);
      end
`endif

      // Randomized traffic; requesters hold valid and payload until accepted.
      rst = 1'b1; req_valid = '0; mem_ready = 1'b0;
      step();
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(0, 99) == 0);
         mem_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || m_acc[i]) begin
               req_valid[i] = ($urandom_range(0, 2) != 0);
               ra[i] = AW'($urandom);
               rd[i] = $urandom;
               rs[i] = SW'($urandom);
            end
         end
`ifdef VRAM_WR_ARBITER_LOCK_EN
         req_lock = N'($urandom);
`endif
         step();
         chk("rnd_ready", 64'(pre_ready), 64'(exp_ready));
         chk("rnd_busy",  64'(pre_busy),  64'(exp_busy));
         chk("rnd_wen",   64'(wen),       64'(m_full));
         chk("rnd_waddr", 64'(waddr),     64'(m_wr.addr));
         chk("rnd_wdata", 64'(wdata),     64'(m_wr.data));
         chk("rnd_wstrb", 64'(wstrb),     64'(m_wr.strb));
         chk("rnd_gid",   64'(grant_id),  64'(m_gid));
`ifndef VRAM_WR_ARBITER_LOCK_EN
         mx = 0;
         for (int i = 0; i < N; i++) if (obs_wait[i] > mx) mx = obs_wait[i];
         chk("rnd_starve_wait", 64'(mx <= N - 1 ? 0 : mx), 64'd0);
`endif
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/vram_wr_arbiter.md
Name: vram_wr_arbiter

Overview:
- Shares the single GPU video-memory write port (waddr/wdata/wen) between NUM_REQ write requesters: the AXI-Lite write controller, the clear/fill engine, the sprite blitter and the text renderer.
- Arbitration is round-robin with one registered output slot.
- Memory-side backpressure comes in through mem_ready.
- Sits between the requester blocks and the VRAM write port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 24, write address width
DATA_WIDTH, 32, write data width
STRB_WIDTH, DATA_WIDTH/8, byte-strobe width
ID_WIDTH, $clog2(NUM_REQ), grant index width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  NUM_REQ  per-requester write request valid
req_ready  out  NUM_REQ  per-requester accept
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at slice i
req_data  in  NUM_REQ*DATA_WIDTH  packed data
req_strb  in  NUM_REQ*STRB_WIDTH  packed byte strobes
waddr  out  ADDR_WIDTH  memory write address
wdata  out  DATA_WIDTH  memory write data
wstrb  out  STRB_WIDTH  memory byte strobes
wen  out  1  memory write valid
mem_ready  in  1  memory accepts current write
grant_id  out  ID_WIDTH  index of requester owning the output slot
busy  out  1  slot full or any req_valid high

Behaviour:
- Reset (rst=1 at posedge):
  - wen=0; waddr, wdata and wstrb = 0; grant_id=0.
  - Round-robin pointer = 0.
  - req_ready is forced to all-zero while rst=1.
  - Any pending slot entry is dropped, with no write issued.
- State machine:
  - EMPTY: slot free.
  - FULL: wen=1, slot holds one write.
  - EMPTY -> FULL on any accepted request.
  - FULL -> EMPTY when mem_ready=1 and no new accept.
  - FULL -> FULL when mem_ready=1 and a new accept happens in the same cycle (back-to-back, full throughput).
  - FULL stays FULL while mem_ready=0.
- can_accept = (state==EMPTY) || mem_ready.
- Winner: first i with req_valid[i], searching from ptr upward modulo NUM_REQ.
- req_ready[winner]=1 only when can_accept; every other ready bit is 0. req_ready is combinational from req_valid, ptr, state and mem_ready.
- Accept: req_valid[i] && req_ready[i].
  - The slot loads that requester's addr/data/strb.
  - grant_id is set to i.
  - ptr is set to (i+1) mod NUM_REQ.
- Latency: accepted at edge N; wen=1 with that data from cycle N+1. The write completes at the first edge with wen && mem_ready.
- Hold rule: waddr, wdata, wstrb and grant_id are stable while wen=1 and mem_ready=0.
- When wen=0: waddr, wdata and wstrb are driven to 0.
- Requesters must keep valid and payload stable until ready. The arbiter does not buffer unaccepted requests.
- Writes with wstrb=0 are forwarded unchanged.
- No requests pending: ptr is unchanged and no state change occurs.
- A single requester that is continuously valid gets every slot, one write per cycle while mem_ready=1.
- With all requesters valid, grants follow ptr order: ptr, ptr+1, and so on.
- Starvation bound: a valid requester is granted within NUM_REQ accepts.

Optional Feature:
- Macro: VRAM_WR_ARBITER_LOCK_EN.
- When defined:
  - Adds input req_lock (NUM_REQ).
  - If the accepted requester had req_lock[i]=1, ptr stays at i, so i keeps top priority for the next accept.
  - A lock counter (4 bits) limits a run to 16 consecutive locked accepts. After that, ptr advances to i+1 regardless of lock, and the counter clears.
  - The counter also clears on any unlocked accept or on reset.
- When undefined: no req_lock port; pure round-robin as above.

Decomposition:
- Package vram_arb_pkg holds:
  - vram_wr_t packed struct {addr, data, strb}, parameterised by the package constants.
  - Default ADDR_WIDTH/DATA_WIDTH constants.
  - arb_state_t enum {EMPTY, FULL}.
  - LOCK_MAX = 16.
- Sub-module rr_picker: purely combinational winner selection. Inputs req mask and ptr; outputs one-hot grant, index and any. Reusable by the read-side arbiter.

Test Plan:
1. Reset check: rst high 3 cycles with all req_valid=1 -> req_ready=0, wen=0, waddr=0 throughout. First cycle after rst: req_ready=4'b0001.
2. Single requester: req2 valid with addr=0x000100, data=0xDEADBEEF, strb=0xF, mem_ready=1 -> req_ready[2]=1 same cycle; next cycle wen=1, waddr=0x000100, wdata=0xDEADBEEF, grant_id=2.
3. Round-robin: all 4 valid continuously, mem_ready=1, ptr=0 -> grant_id sequence 0,1,2,3,0,1, one write per cycle.
4. Backpressure: slot FULL with req1's write, mem_ready=0 for 5 cycles -> wen and payload stable, all req_ready=0. mem_ready=1 -> req1 write retires and the next winner is accepted in the same cycle.
5. Reset mid-operation: slot FULL with mem_ready=0, assert rst one cycle -> wen=0 next cycle, no write observed, ptr=0.
6. (LOCK_EN) req0 valid with req_lock[0]=1, req3 valid -> 16 consecutive grants to 0, then grant to 3.
